// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I multi-cycle control FSM.
// Steps a shared datapath through FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
// It drives every datapath enable and mux select, and handshakes with a
// single unified memory port. A memory request that waits too long, an
// illegal opcode, or a SYSTEM instruction parks the FSM in HALT. Only reset
// leaves HALT.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-low reset
//   instr[31:0]   IR contents, valid from DECODE onward
//   mem_ready     memory completes the current request this cycle
//   branch_taken  branch comparator result, valid in EXEC
//   mem_req / mem_we / mem_is_fetch   memory request, store flag, fetch flag
//   ir_we, pc_we, rf_we               datapath write enables
//   pc_sel[1:0]   00 pc+4, 01 pc+imm, 10 alu_result & ~1
//   wb_sel[1:0]   00 ALU, 01 memory data, 10 pc+4
//   alu_a_sel[1:0]  00 rs1, 01 PC, 10 zero
//   alu_b_sel     0 rs2, 1 imm
//   alu_op[1:0]   00 add, 01 decode funct3/funct7, 10 compare
//   retire        one-cycle pulse per completed instruction
//   halt / illegal / bus_err   sticky status flags, registered
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_is_fetch,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic [1:0]  alu_a_sel,
  output logic        alu_b_sel,
  output logic [1:0]  alu_op,
  output logic        retire,
  output logic        halt,
  output logic        illegal,
  output logic        bus_err
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  localparam logic [4:0] OP_R      = 5'b01100;
  localparam logic [4:0] OP_IARITH = 5'b00100;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;

  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            halt_q, illegal_q, bus_err_q;
  logic            set_illegal, set_bus_err;
  logic [4:0]      op;
  logic            legal;
  logic            unused_instr;

  assign op           = instr[6:2];
  assign unused_instr = ^instr[31:7];

  always_comb begin
    legal = 1'b0;
    if (instr[1:0] == 2'b11) begin
      case (op)
        OP_R, OP_IARITH, OP_LOAD, OP_STORE, OP_BRANCH,
        OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM: legal = 1'b1;
        default:                                      legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    set_illegal  = 1'b0;
    set_bus_err  = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_is_fetch = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 2'b00;
    rf_we        = 1'b0;
    wb_sel       = 2'b00;
    alu_a_sel    = 2'b00;
    alu_b_sel    = 1'b0;
    alu_op       = 2'b00;
    retire       = 1'b0;

    // ALU selects are decoded the same way in EXEC, MEM and WB. This keeps
    // the memory address and the writeback result stable past EXEC.
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      case (op)
        OP_R:      begin alu_a_sel = 2'b00; alu_b_sel = 1'b0; alu_op = 2'b01; end
        OP_IARITH: begin alu_a_sel = 2'b00; alu_b_sel = 1'b1; alu_op = 2'b01; end
        OP_LOAD, OP_STORE, OP_JALR:
                   begin alu_a_sel = 2'b00; alu_b_sel = 1'b1; alu_op = 2'b00; end
        OP_LUI:    begin alu_a_sel = 2'b10; alu_b_sel = 1'b1; alu_op = 2'b00; end
        OP_AUIPC:  begin alu_a_sel = 2'b01; alu_b_sel = 1'b1; alu_op = 2'b00; end
        OP_BRANCH: begin alu_a_sel = 2'b00; alu_b_sel = 1'b0; alu_op = 2'b10; end
        default:   begin alu_a_sel = 2'b00; alu_b_sel = 1'b0; alu_op = 2'b00; end
      endcase
    end

    case (state_q)
      S_FETCH: begin
        mem_req      = 1'b1;
        mem_is_fetch = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = S_HALT;
          set_bus_err = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DECODE: begin
        if (!legal) begin
          state_d     = S_HALT;
          set_illegal = 1'b1;
        end else if (op == OP_SYSTEM) begin
          state_d = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (op == OP_BRANCH) begin
          pc_we   = 1'b1;
          pc_sel  = branch_taken ? 2'b01 : 2'b00;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (op == OP_LOAD || op == OP_STORE) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (op == OP_STORE);
        if (mem_ready) begin
          if (op == OP_STORE) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d     = S_HALT;
          set_bus_err = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
        if (op == OP_LOAD)                      wb_sel = 2'b01;
        else if (op == OP_JAL || op == OP_JALR) wb_sel = 2'b10;
        if (op == OP_JAL)       pc_sel = 2'b01;
        else if (op == OP_JALR) pc_sel = 2'b10;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase

    if (state_d != state_q) cnt_d = '0;

    // The reset cycle must present a quiet datapath. The FSM itself is
    // restored by the register block.
    if (!rst) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_is_fetch = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_sel       = 2'b00;
      rf_we        = 1'b0;
      wb_sel       = 2'b00;
      alu_a_sel    = 2'b00;
      alu_b_sel    = 1'b0;
      alu_op       = 2'b00;
      retire       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      halt_q    <= 1'b0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      halt_q    <= halt_q | (state_d == S_HALT);
      illegal_q <= illegal_q | set_illegal;
      bus_err_q <= bus_err_q | set_bus_err;
    end
  end

  assign halt    = halt_q;
  assign illegal = illegal_q;
  assign bus_err = bus_err_q;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control unit for the RV32I core. It sequences a shared datapath (PC, IR, register file, ALU, immediate generator, single memory port) through fetch, decode, execute, memory and writeback states. It handshakes with the unified instruction/data memory port and drives every datapath enable and mux select. It sits beside the immediate generator and consumes the same latched instruction word that the immediate generator decodes.

## Interface
Parameters:
- TIMEOUT, 16: max cycles a memory request may wait for `mem_ready` before a bus error (≥2).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-low
- instr  in  32  IR contents; valid from DECODE onward
- mem_ready  in  1  memory completes the current request this cycle
- branch_taken  in  1  branch comparator result, valid in EXEC
- mem_req  out  1  memory request
- mem_we  out  1  request is a store
- mem_is_fetch  out  1  request is an instruction fetch (address = PC)
- ir_we  out  1  latch memory read data into IR
- pc_we  out  1  update PC
- pc_sel  out  2  00 = pc+4, 01 = pc+imm, 10 = alu_result & ~1
- rf_we  out  1  register-file write
- wb_sel  out  2  00 = ALU, 01 = memory data, 10 = pc+4
- alu_a_sel  out  2  00 = rs1, 01 = PC, 10 = zero
- alu_b_sel  out  1  0 = rs2, 1 = imm
- alu_op  out  2  00 = add, 01 = decode funct3/funct7, 10 = compare
- retire  out  1  one-cycle pulse when an instruction completes
- halt  out  1  sticky; core stopped
- illegal  out  1  sticky; illegal opcode caused the halt
- bus_err  out  1  sticky; memory timeout caused the halt

## Operation
- Opcode field: op = instr[6:2].
  - Legal: 01100 R, 00100 I-arith, 00000 LOAD, 01000 STORE, 11000 BRANCH, 11011 JAL, 11001 JALR, 01101 LUI, 00101 AUIPC, 11100 SYSTEM.
  - Illegal: any other op, or instr[1:0] ≠ 11.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. All outputs are combinational from state, op and the inputs. halt, illegal and bus_err are registered.
- FETCH:
  - Drives mem_req=1, mem_is_fetch=1.
  - On mem_ready: ir_we=1 and move to DECODE. Otherwise stay.
- DECODE:
  - Illegal op → HALT, set illegal.
  - SYSTEM → HALT (ECALL/EBREAK stop the core).
  - Otherwise → EXEC.
  - No enables are asserted.
- EXEC, by op:
  - R: alu_a=rs1, alu_b=rs2, alu_op=01.
  - I-arith: alu_a=rs1, alu_b=imm, alu_op=01.
  - LOAD/STORE/JALR: alu_a=rs1, alu_b=imm, alu_op=00.
  - LUI: alu_a=zero, alu_b=imm, alu_op=00.
  - AUIPC: alu_a=PC, alu_b=imm, alu_op=00.
  - BRANCH: alu_a=rs1, alu_b=rs2, alu_op=10; pc_we=1, pc_sel = branch_taken ? 01 : 00, retire=1, → FETCH.
  - LOAD/STORE → MEM. All others → WB.
- MEM:
  - Drives mem_req=1, mem_we=(op==STORE), with the address taken from the ALU result.
  - On mem_ready, STORE: pc_we=1, pc_sel=00, retire=1, → FETCH.
  - On mem_ready, LOAD: → WB.
- WB:
  - rf_we=1 and pc_we=1, retire=1, → FETCH.
  - wb_sel: 01 for LOAD, 10 for JAL/JALR, 00 otherwise.
  - pc_sel: 01 for JAL, 10 for JALR, 00 otherwise.
- ALU selects in MEM and WB hold their EXEC values, so the address and result stay stable.
- Timeout counter:
  - Clears on every state change. Increments each cycle in FETCH/MEM while mem_ready=0.
  - When the count reaches TIMEOUT-1 with mem_ready still 0: → HALT, set bus_err. The request is abandoned and no enable is asserted.
- HALT:
  - Absorbing state. All enables and mem_req are 0 and halt=1.
  - Only reset leaves HALT.

## Timing
- While rst=0 at a clock edge:
  - State becomes FETCH and the counter clears.
  - halt, illegal and bus_err clear.
  - All combinational outputs are forced to 0 during the reset cycle, including mem_req.
- Reset mid-instruction aborts it with no pc_we or rf_we. The first mem_req follows in the cycle after rst returns high.
- Cycles per instruction with zero-wait memory (mem_ready high in the request cycle):
  - BRANCH: 3.
  - R, I, LUI, AUIPC, JAL, JALR, STORE: 4.
  - LOAD: 5.
- Each memory wait cycle adds exactly 1 cycle.
- ir_we, pc_we, rf_we and retire are single-cycle pulses. Exactly one retire per completed instruction. Never two write enables for the same target in one instruction.
- mem_req stays high and mem_we/mem_is_fetch stay stable from the assertion of mem_req until the mem_ready cycle. mem_req deasserts in the cycle after mem_ready unless the next state also requests.
- mem_ready while mem_req=0 is ignored.
- Timeout with mem_ready arriving on the final count cycle: mem_ready wins and the request completes normally.

## Test plan
- Reset release, zero-wait memory, instr=0x00500093 (addi x1,x0,5):
  - Cycles are FETCH, DECODE, EXEC, WB.
  - WB cycle has rf_we=1, pc_we=1, pc_sel=00, retire=1.
  - mem_req=1 again on cycle 5.
- LOAD 0x0000A103, mem_ready delayed 3 cycles in both FETCH and MEM:
  - Instruction completes in 11 cycles.
  - WB has wb_sel=01, rf_we=1.
  - mem_we=0 throughout.
- BEQ with branch_taken=1, then again with branch_taken=0:
  - Retire on cycle 3 in both cases, with pc_sel=01 and 00 respectively.
  - rf_we never asserted.
- JALR 0x000080E7: WB has wb_sel=10, pc_sel=10, rf_we=1, pc_we=1.
- instr=0x0000007F (op 11111):
  - HALT entered after DECODE; illegal=1, halt=1.
  - No further mem_req until rst=0, after which all flags read 0.
- mem_ready held low in FETCH with TIMEOUT=16: bus_err=1 and halt=1 after 16 request cycles, with no ir_we.
- Repeat with mem_ready asserted on the 16th cycle: normal DECODE follows and bus_err=0.
